// File: rtl/seq_shift_rotate.sv
// rtl/seq_shift_rotate.sv - iterative 16-bit shifter/rotator, one bit position per clock
// Same op encoding as the barrel shifter; start/busy/done handshake.
module seq_shift_rotate #(
    parameter int WIDTH = 16,
    parameter int CNTW  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] In,
    input  logic [1:0]       Op,
    input  logic [CNTW-1:0]  Cnt,
    output logic [WIDTH-1:0] Out,
    output logic             busy,
    output logic             done
);

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_RUN  = 2'b01;
    localparam logic [1:0] ST_DONE = 2'b10;

    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_ROR = 2'b01;
    localparam logic [1:0] OP_SRL = 2'b10;
    localparam logic [1:0] OP_ROL = 2'b11;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [1:0]       op_q, op_d;
    logic [CNTW-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0] step;

    always_comb begin
        step = data_q;
        case (op_q)
            OP_SLL:  step = {data_q[WIDTH-2:0], 1'b0};
            OP_ROR:  step = {data_q[0], data_q[WIDTH-1:1]};
            OP_SRL:  step = {1'b0, data_q[WIDTH-1:1]};
            OP_ROL:  step = {data_q[WIDTH-2:0], data_q[WIDTH-1]};
            default: step = data_q;
        endcase
    end

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        case (state_q)
            // DONE accepts a new start just like IDLE, giving back-to-back issue
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    data_d  = In;
                    op_d    = Op;
                    cnt_d   = Cnt;
                    state_d = (Cnt != '0) ? ST_RUN : ST_DONE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                data_d = step;
                cnt_d  = cnt_q - 1'b1;
                if (cnt_q == CNTW'(1)) begin
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            data_q  <= '0;
            op_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
        end
    end

    assign Out  = data_q;
    assign busy = (state_q == ST_RUN);
    assign done = (state_q == ST_DONE);

endmodule

// File: tb/tb_seq_shift_rotate.sv
// tb/tb_seq_shift_rotate.sv - self-checking bench for seq_shift_rotate
module tb_seq_shift_rotate;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] In;
    logic [1:0]  Op;
    logic [3:0]  Cnt;
    logic [15:0] Out;
    logic        busy;
    logic        done;

    int total = 0;
    int bad   = 0;
    logic [15:0] last_exp;

    seq_shift_rotate #(.WIDTH(16), .CNTW(4)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .In    (In),
        .Op    (Op),
        .Cnt   (Cnt),
        .Out   (Out),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Whole-word reference: shifts and rotates from plain operators on a doubled word
    function automatic logic [15:0] ref_shift(input logic [15:0] a, input logic [1:0] op,
                                              input logic [3:0] n);
        logic [31:0] w;
        logic [15:0] r;
        w = {a, a};
        case (op)
            2'b00: r = a << n;
            2'b10: r = a >> n;
            2'b11: begin w = w << n; r = w[31:16]; end
            default: begin w = w >> n; r = w[15:0]; end
        endcase
        return r;
    endfunction

    // mode 0: start low while running; 1: random ignored starts; 2: persistent start with In=FFFF, Cnt=1
    task automatic run_op(input logic [15:0] a, input logic [1:0] op, input logic [3:0] n,
                          input int mode);
        int lat;
        lat = (n == 4'd0) ? 1 : int'(n) + 1;
        last_exp = ref_shift(a, op, n);
        @(negedge clk);
        start = 1'b1; In = a; Op = op; Cnt = n;
        for (int k = 1; k <= lat; k++) begin
            @(posedge clk); #1;
            check("busy", 32'(busy), 32'(k < lat));
            check("done", 32'(done), 32'(k == lat));
            if (k == lat) begin
                check("out", 32'(Out), 32'(last_exp));
            end else begin
                @(negedge clk);
                case (mode)
                    0:       start = 1'b0;
                    1:       start = 1'($urandom_range(0, 1));
                    default: start = 1'b1;
                endcase
                if (mode == 2) begin
                    In = 16'hFFFF; Cnt = 4'd1;
                end else begin
                    In = 16'($urandom); Op = 2'($urandom); Cnt = 4'($urandom);
                end
            end
        end
    endtask

    task automatic idle_cycle(input logic [15:0] hold);
        @(negedge clk);
        start = 1'b0; In = 16'($urandom); Op = 2'($urandom); Cnt = 4'($urandom);
        @(posedge clk); #1;
        check("idle_done", 32'(done), 32'd0);
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_hold", 32'(Out), 32'(hold));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog timeout at %0t", $time);
        $fatal(1);
    end

    initial begin
        logic seen_done;
        logic [15:0] a;
        logic [1:0]  op;
        logic [3:0]  n;

        rst = 1'b1; start = 1'b0; In = '0; Op = '0; Cnt = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out", 32'(Out), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);

        // reset wins over a simultaneous start
        @(negedge clk);
        start = 1'b1; In = 16'hBEEF; Op = 2'b00; Cnt = 4'd5;
        @(posedge clk); #1;
        check("rst_start_busy", 32'(busy), 32'd0);
        check("rst_start_out", 32'(Out), 32'd0);
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        @(posedge clk); #1;
        check("post_rst_busy", 32'(busy), 32'd0);
        check("post_rst_done", 32'(done), 32'd0);

        run_op(16'h0001, 2'b00, 4'd4, 0);
        check("sll_const", 32'(Out), 32'h0010);
        idle_cycle(16'h0010);

        run_op(16'h0001, 2'b01, 4'd1, 0);
        check("ror_const", 32'(Out), 32'h8000);
        idle_cycle(16'h8000);
        run_op(16'h8000, 2'b10, 4'd15, 0);
        check("srl_const", 32'(Out), 32'h0001);
        idle_cycle(16'h0001);

        run_op(16'hA5F0, 2'b11, 4'd0, 0);
        check("rol0_const", 32'(Out), 32'hA5F0);
        run_op(16'hA5F0, 2'b11, 4'd4, 0);
        check("rol4_const", 32'(Out), 32'h5F0A);
        idle_cycle(16'h5F0A);

        run_op(16'h00FF, 2'b00, 4'd3, 2);
        check("busy_ignore_const", 32'(Out), 32'h07F8);
        idle_cycle(16'h07F8);

        // reset during RUN discards the operation
        @(negedge clk);
        start = 1'b1; In = 16'hF000; Op = 2'b10; Cnt = 4'd8;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
        check("mid_busy", 32'(busy), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        check("mid_rst_out", 32'(Out), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_done", 32'(done), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        seen_done = 1'b0;
        repeat (12) begin
            @(posedge clk); #1;
            if (done) seen_done = 1'b1;
        end
        check("no_done_after_rst", 32'(seen_done), 32'd0);
        check("out_after_rst", 32'(Out), 32'd0);
        run_op(16'h1357, 2'b01, 4'd6, 0);
        idle_cycle(last_exp);

        run_op(16'h1234, 2'b11, 4'd7, 0);
        run_op(16'h8001, 2'b01, 4'd2, 0);
        run_op(16'h0005, 2'b10, 4'd0, 0);
        run_op(16'hC003, 2'b00, 4'd15, 1);
        idle_cycle(last_exp);

        for (int i = 0; i < 1000; i++) begin
            a  = 16'($urandom);
            op = 2'($urandom);
            n  = 4'($urandom);
            run_op(a, op, n, int'($urandom_range(0, 1)));
            if ($urandom_range(0, 3) == 0) idle_cycle(last_exp);
        end
        idle_cycle(last_exp);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
